// File: rtl/bullet_pkg.sv
// Shared types and field constants for the bullet table and its hit controller.
package bullet_pkg;

    typedef enum logic [1:0] {
        COL_WHITE = 2'd0,
        COL_GREEN = 2'd1,
        COL_BLUE  = 2'd2,
        COL_INERT = 2'd3
    } color_e;

    // Field slices of the packed {x, y} position and {w, h} size words.
    localparam int X_HI = 15;
    localparam int X_LO = 8;
    localparam int Y_HI = 7;
    localparam int Y_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SCAN,
        ST_DRAIN,
        ST_OVER
    } state_e;

endpackage

// File: rtl/bullet_hit_ctrl_if.sv
// Bullet-table bus: slot select, slot readback, run and collide controls.
interface bullet_hit_ctrl_if;
    logic [2:0]  bullet_index;
    logic [15:0] bullet_position;
    logic [15:0] bullet_size;
    logic [1:0]  bullet_color;
    logic        bullet_render;
    logic        bullet_run;
    logic        bullet_collide;

    // The hit controller drives slot select and controls.
    modport master (
        output bullet_index, bullet_run, bullet_collide,
        input  bullet_position, bullet_size, bullet_color, bullet_render
    );

    // The bullet table answers with the selected slot's contents.
    modport slave (
        input  bullet_index, bullet_run, bullet_collide,
        output bullet_position, bullet_size, bullet_color, bullet_render
    );
endinterface

// File: rtl/bullet_hit_ctrl_aabb_overlap.sv
// Strict axis-aligned rectangle overlap; touching edges do not count.
module aabb_overlap
    import bullet_pkg::*;
(
    input  logic [15:0] a_pos,
    input  logic [15:0] a_size,
    input  logic [15:0] b_pos,
    input  logic [15:0] b_size,
    output logic        overlap
);
    // 9-bit sums so a box near the 255 edge cannot wrap around to 0.
    logic [8:0] ax, ay, aw, ah, bx, by, bw, bh;

    assign ax = {1'b0, a_pos[X_HI:X_LO]};
    assign ay = {1'b0, a_pos[Y_HI:Y_LO]};
    assign aw = {1'b0, a_size[X_HI:X_LO]};
    assign ah = {1'b0, a_size[Y_HI:Y_LO]};
    assign bx = {1'b0, b_pos[X_HI:X_LO]};
    assign by = {1'b0, b_pos[Y_HI:Y_LO]};
    assign bw = {1'b0, b_size[X_HI:X_LO]};
    assign bh = {1'b0, b_size[Y_HI:Y_LO]};

    assign overlap = (bx < ax + aw) && (ax < bx + bw) &&
                     (by < ay + ah) && (ay < by + bh);
endmodule

// File: rtl/bullet_hit_ctrl.sv
// Per-frame bullet scan: contact test, damage/heal, HP, iframes, game over.
module bullet_hit_ctrl
    import bullet_pkg::*;
#(
    parameter int N_SLOTS = 3,
    parameter int HP_INIT = 20,
    parameter int DMG     = 4,
    parameter int IFRAMES = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              game_start,
    input  logic [15:0]       player_pos,
    input  logic [15:0]       player_size,
    input  logic              player_moving,
    bullet_hit_ctrl_if.master bus,
    output logic [7:0]        hp,
    output logic              hit,
    output logic              heal,
    output logic              game_over
);
    localparam logic [7:0] HP_MAX = 8'(HP_INIT);
    localparam logic [7:0] DMG_V  = 8'(DMG);
    localparam logic [7:0] IFR_V  = 8'(IFRAMES);
    localparam logic [2:0] LAST   = 3'(N_SLOTS - 1);

    state_e     state_q;
    logic [2:0] idx_q;
    logic       run_q, collide_q, hit_q, heal_q, over_q;
    logic [7:0] hp_q, ifr_q;

    logic       ovl, contact, do_dmg, do_heal;
    logic [8:0] hp_sum;
    logic [7:0] hp_dmg_d, hp_heal_d;

    aabb_overlap u_ovl (
        .a_pos   (player_pos),
        .a_size  (player_size),
        .b_pos   (bus.bullet_position),
        .b_size  (bus.bullet_size),
        .overlap (ovl)
    );

    // Effect of the currently indexed slot; iframe gates damage, never heals.
    always_comb begin
        contact   = bus.bullet_render && ovl;
        do_dmg    = contact && (ifr_q == 8'd0) &&
                    ((bus.bullet_color == COL_WHITE) ||
                     (bus.bullet_color == COL_BLUE && player_moving));
        do_heal   = contact && (bus.bullet_color == COL_GREEN);
        hp_sum    = {1'b0, hp_q} + {1'b0, DMG_V};
        hp_heal_d = (hp_sum >= {1'b0, HP_MAX}) ? HP_MAX : hp_sum[7:0];
        hp_dmg_d  = (hp_q > DMG_V) ? (hp_q - DMG_V) : 8'd0;
    end

    // Frame sequencer; effects of slot k land one cycle after it is selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            run_q     <= 1'b0;
            collide_q <= 1'b0;
            hit_q     <= 1'b0;
            heal_q    <= 1'b0;
            over_q    <= 1'b0;
            hp_q      <= HP_MAX;
            ifr_q     <= 8'd0;
        end else begin
            hit_q     <= 1'b0;
            heal_q    <= 1'b0;
            collide_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (game_start) begin
                        state_q <= ST_WAIT;
                        hp_q    <= HP_MAX;
                        ifr_q   <= 8'd0;
                        run_q   <= 1'b1;
                        over_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (frame_tick) begin
                        state_q <= ST_SCAN;
                        idx_q   <= 3'd0;
                        if (ifr_q != 8'd0) ifr_q <= ifr_q - 8'd1;
                    end
                end
                ST_SCAN: begin
                    if (do_dmg) begin
                        hp_q      <= hp_dmg_d;
                        ifr_q     <= IFR_V;
                        hit_q     <= 1'b1;
                        collide_q <= 1'b1;
                    end else if (do_heal) begin
                        hp_q      <= hp_heal_d;
                        heal_q    <= 1'b1;
                        collide_q <= 1'b1;
                    end
                    if (idx_q == LAST) begin
                        state_q <= ST_DRAIN;
                        idx_q   <= 3'd0;
                    end else begin
                        idx_q   <= idx_q + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (hp_q == 8'd0) begin
                        state_q <= ST_OVER;
                        run_q   <= 1'b0;
                        over_q  <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.bullet_index   = idx_q;
    assign bus.bullet_run     = run_q;
    assign bus.bullet_collide = collide_q;
    assign hp        = hp_q;
    assign hit       = hit_q;
    assign heal      = heal_q;
    assign game_over = over_q;
endmodule
